free_list_mw: RTL and testbench
===============================

# free_list_mw

Multi-lane physical-register free list for the rename stage. It holds the indices of unallocated physical registers in a circular buffer and hands out up to DEQ_WIDTH indices per cycle to rename. It accepts up to ENQ_WIDTH freed indices per cycle from ROB commit. It keeps a retired-head pointer so that a pipeline flush returns every speculatively allocated register in one cycle. It sits between the ROB commit port and the rename/dispatch stage, and replaces the single-lane free list once ID_WIDTH is raised above 1.

## Interface
- DEPTH, default PRF_DEPTH - ARF_DEPTH (32): number of entries; power of two.
- PRF_IDX, default cpu_params PRF_IDX (6): width of a physical index.
- ARF_DEPTH, default 32: first free physical index after reset.
- DEQ_WIDTH, default ID_WIDTH: allocation lanes per cycle.
- ENQ_WIDTH, default COMMIT_WIDTH: free/commit lanes per cycle.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset; the block resets when rst is 0 at a rising edge.
- dequeue_en  in  DEQ_WIDTH  per-lane allocation request from rename (rd_arch != 0).
- dequeue_phy  out  DEQ_WIDTH x PRF_IDX  allocated index per lane (combinational).
- dequeue_ready  out  1  at least DEQ_WIDTH entries are free.
- enqueue_en  in  ENQ_WIDTH  per-lane commit of an instruction with rd_arch != 0.
- enqueue_phy  in  ENQ_WIDTH x PRF_IDX  stale physical index being freed.
- flush  in  1  mispredict flush from ROB head.
- count  out  $clog2(DEPTH)+1  registered number of free entries.
- empty  out  1  count == 0.

## Operation
- Storage: DEPTH x PRF_IDX array. There are three pointers, each of width $clog2(DEPTH)+1 (the extra bit is the wrap bit): head (speculative), retired_head, and tail.
- count = tail - head, computed modulo 2^(idx+1). full ⇔ count == DEPTH.
- Reset: entry i = ARF_DEPTH + i. head = retired_head = 0. tail = DEPTH with wrap bit set. count = DEPTH, dequeue_ready = 1, empty = 0.
- Dequeue lane compaction: lane k's dequeue_phy = mem[head + r_k], where r_k = number of set dequeue_en bits in lanes below k. Lanes with dequeue_en = 0 also drive their value; the value is don't-care.
- Dequeue handshake: allocation is all-or-nothing.
  - Rename must hold dequeue_en while dequeue_ready = 0 is treated as a stall; no state changes in that case.
  - When dequeue_ready = 1, head advances by popcount(dequeue_en).
- Enqueue lane compaction: lane j writes mem[tail + s_j], where s_j = number of set enqueue_en bits in lanes below j. tail advances by popcount(enqueue_en).
- Each enqueue also advances retired_head by popcount(enqueue_en). Every committed rd allocation has retired, and its stale register is returned.
- Flush:
  - head <= retired_head + popcount(enqueue_en) for that cycle.
  - Dequeue requests in the flush cycle are ignored.
  - Enqueues in the same cycle are applied normally.
- Overflow (count + popcount(enqueue_en) > DEPTH) cannot occur by construction. A simulation assertion fires if it does. Dequeue with dequeue_ready = 0 raises an assertion only if rename advances anyway.
- All pointer arithmetic wraps modulo 2·DEPTH. Array addressing uses the low $clog2(DEPTH) bits.

## Timing
- dequeue_phy and dequeue_ready are valid in the same cycle as dequeue_en. Both derive from registered head/count only; there is no comb path from enqueue_en.
- Freed entries become allocatable the cycle after enqueue (no bypass). An enqueue into an empty list yields dequeue_ready one cycle later at the earliest.
- Simultaneous dequeue and enqueue in a cycle:
  - Both apply.
  - Next count = count - deq + enq.
  - Wrap-around is handled by the modulo pointers.
- Flush latency is one cycle. In the cycle after flush, count = tail' - retired_head'.
- Reset overrides flush and all enqueue/dequeue activity. Reset in the middle of a flush or with pending enqueues restores the full list.

## Structure
- cpu_params additions:
  - COMMIT_WIDTH (default 1).
  - FREELIST_DEPTH = PRF_DEPTH - ARF_DEPTH.
  - FREELIST_IDX = $clog2(FREELIST_DEPTH).
- One sub-module, prefix_count #(WIDTH): produces per-lane exclusive prefix counts and a total popcount. It is instantiated once for dequeue and once for enqueue.
- Pointer and array logic stays in free_list_mw. No new package typedefs are needed.

## Test plan
Benches use DEQ_WIDTH = ENQ_WIDTH = 2 and DEPTH = 32.

1. Reset, then dequeue_en = 2'b11 for one cycle -> dequeue_phy = {33, 32}. count goes 32 -> 30. Next cycle dequeue_phy = {35, 34}.
2. dequeue_en = 2'b10 -> lane1 receives 32 and head advances by 1. Next cycle dequeue_en = 2'b11 gives {34, 33}.
3. Drain to count = 1 -> dequeue_ready = 0. Holding dequeue_en = 2'b11 leaves count unchanged. Enqueue phy 5 -> count = 2 and dequeue_ready = 1 the following cycle. Dequeuing then returns the last entry and 5.
4. Allocate 6 registers, commit 2 (enqueue 7 and 9), then flush -> count = 32 - 6 + 2 + 4 = 32. The next allocation returns 34 (retired_head position).
5. Flush in the same cycle as enqueue_en = 2'b11 -> retired_head includes both. The ignored dequeue leaves head = retired_head + 2.
6. Run 100 random dequeue/enqueue cycles with no loss or duplicates -> the multiset of {free ∪ outstanding} equals {32..63} ∪ freed values. Pointers wrap past 63 at least twice. Apply reset mid-sequence -> the state fully matches the post-reset state.

Source files
------------

// File: rtl/free_list_mw_pkg.sv
// Shared CPU sizing constants for the rename-stage free list.
package free_list_mw_pkg;

    localparam int CPU_PRF_DEPTH  = 64;
    localparam int CPU_ARF_DEPTH  = 32;
    localparam int CPU_PRF_IDX    = $clog2(CPU_PRF_DEPTH);
    localparam int ID_WIDTH       = 2;
    localparam int COMMIT_WIDTH   = 1;
    localparam int FREELIST_DEPTH = CPU_PRF_DEPTH - CPU_ARF_DEPTH;
    localparam int FREELIST_IDX   = $clog2(FREELIST_DEPTH);

endpackage

// File: rtl/free_list_mw_prefix_count.sv
// Exclusive per-lane prefix count of set enable bits plus their total.
module prefix_count
    import free_list_mw_pkg::*;
#(
    parameter  int WIDTH = 2,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]         en,
    output logic [WIDTH-1:0][CW-1:0] prefix,
    output logic [CW-1:0]            total
);

    logic [CW-1:0] acc;

    always_comb begin
        acc    = '0;
        prefix = '0;
        for (int i = 0; i < WIDTH; i++) begin
            prefix[i] = acc;
            acc       = acc + CW'(en[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/free_list_mw.sv
// Multi-lane physical-register free list: compacted allocate/free lanes over a
// circular buffer, with a retired head so a flush reclaims all speculative allocations.
module free_list_mw
    import free_list_mw_pkg::*;
#(
    parameter  int DEPTH     = FREELIST_DEPTH,
    parameter  int PRF_IDX   = CPU_PRF_IDX,
    parameter  int ARF_DEPTH = CPU_ARF_DEPTH,
    parameter  int DEQ_WIDTH = ID_WIDTH,
    parameter  int ENQ_WIDTH = COMMIT_WIDTH,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DEQ_WIDTH-1:0]              dequeue_en,
    output logic [DEQ_WIDTH-1:0][PRF_IDX-1:0] dequeue_phy,
    output logic                              dequeue_ready,
    input  logic [ENQ_WIDTH-1:0]              enqueue_en,
    input  logic [ENQ_WIDTH-1:0][PRF_IDX-1:0] enqueue_phy,
    input  logic                              flush,
    output logic [CNT_W-1:0]                  count,
    output logic                              empty
);

    localparam int IDXW = $clog2(DEPTH);
    localparam int PTRW = IDXW + 1;
    localparam int DCW  = $clog2(DEQ_WIDTH + 1);
    localparam int ECW  = $clog2(ENQ_WIDTH + 1);

    logic [PRF_IDX-1:0] mem [DEPTH];

    logic [PTRW-1:0] head;
    logic [PTRW-1:0] retired_head;
    logic [PTRW-1:0] tail;
    logic [PTRW-1:0] head_next;
    logic [PTRW-1:0] retired_next;
    logic [PTRW-1:0] tail_next;

    logic [DEQ_WIDTH-1:0][DCW-1:0] deq_prefix;
    logic [DCW-1:0]                deq_total;
    logic [ENQ_WIDTH-1:0][ECW-1:0] enq_prefix;
    logic [ECW-1:0]                enq_total;

    logic [PTRW-1:0] rd_ptr [DEQ_WIDTH];
    logic [PTRW-1:0] wr_ptr [ENQ_WIDTH];

    prefix_count #(.WIDTH(DEQ_WIDTH)) u_deq_count (
        .en     (dequeue_en),
        .prefix (deq_prefix),
        .total  (deq_total)
    );

    prefix_count #(.WIDTH(ENQ_WIDTH)) u_enq_count (
        .en     (enqueue_en),
        .prefix (enq_prefix),
        .total  (enq_total)
    );

    // Status depends only on registered pointers, so rename never sees a path from commit.
    assign count         = CNT_W'(tail - head);
    assign dequeue_ready = (count >= CNT_W'(DEQ_WIDTH));
    assign empty         = (count == '0);

    always_comb begin
        dequeue_phy = '0;
        for (int k = 0; k < DEQ_WIDTH; k++) begin
            rd_ptr[k]      = head + PTRW'(deq_prefix[k]);
            dequeue_phy[k] = mem[rd_ptr[k][IDXW-1:0]];
        end
    end

    always_comb begin
        for (int j = 0; j < ENQ_WIDTH; j++) begin
            wr_ptr[j] = tail + PTRW'(enq_prefix[j]);
        end
    end

    // A flush rewinds the speculative head to the retired point, including this cycle's commits.
    always_comb begin
        tail_next    = tail + PTRW'(enq_total);
        retired_next = retired_head + PTRW'(enq_total);
        head_next    = head;
        if (flush) begin
            head_next = retired_next;
        end else if (dequeue_ready) begin
            head_next = head + PTRW'(deq_total);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head         <= '0;
            retired_head <= '0;
            tail         <= PTRW'(DEPTH);
        end else begin
            head         <= head_next;
            retired_head <= retired_next;
            tail         <= tail_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PRF_IDX'(ARF_DEPTH + i);
            end
        end else begin
            for (int j = 0; j < ENQ_WIDTH; j++) begin
                if (enqueue_en[j]) begin
                    mem[wr_ptr[j][IDXW-1:0]] <= enqueue_phy[j];
                end
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        (int'(count) + int'(enq_total)) <= DEPTH);

    a_stall_holds_head: assert property (@(posedge clk) disable iff (!rst)
        (!dequeue_ready && !flush) |=> (head == $past(head)));

endmodule

// File: tb/tb_free_list_mw.sv
// Randomized scoreboard bench for free_list_mw against a queue-level model of the free list.
module tb_free_list_mw;

    localparam int DEPTH   = 32;
    localparam int PRF_IDX = 6;
    localparam int ARF     = 32;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic                  clk;
    logic                  rst;
    logic [1:0]            dequeue_en;
    logic [1:0][PRF_IDX-1:0] dequeue_phy;
    logic                  dequeue_ready;
    logic [1:0]            enqueue_en;
    logic [1:0][PRF_IDX-1:0] enqueue_phy;
    logic                  flush;
    logic [CNT_W-1:0]      count;
    logic                  empty;

    free_list_mw #(
        .DEPTH     (DEPTH),
        .PRF_IDX   (PRF_IDX),
        .ARF_DEPTH (ARF),
        .DEQ_WIDTH (2),
        .ENQ_WIDTH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dequeue_en    (dequeue_en),
        .dequeue_phy   (dequeue_phy),
        .dequeue_ready (dequeue_ready),
        .enqueue_en    (enqueue_en),
        .enqueue_phy   (enqueue_phy),
        .flush         (flush),
        .count         (count),
        .empty         (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int rdy;
        int emp;
    } status_t;

    // Model: free values in allocation order, speculative allocations oldest first, and
    // architecturally mapped registers available for freeing.
    int      free_q[$];
    int      spec_q[$];
    int      mapped_q[$];
    int      exp_q[$];
    status_t stat_q[$];

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void model_reset();
        free_q.delete();
        spec_q.delete();
        mapped_q.delete();
        for (int i = 0; i < DEPTH; i++) free_q.push_back(ARF + i);
        for (int i = 0; i < ARF; i++) mapped_q.push_back(i);
    endfunction

    function automatic void drop_mapped(input int v);
        for (int i = 0; i < mapped_q.size(); i++) begin
            if (mapped_q[i] == v) begin
                mapped_q.delete(i);
                return;
            end
        end
    endfunction

    function automatic int pick_mapped();
        int idx;
        int v;
        idx = $urandom_range(0, mapped_q.size() - 1);
        v   = mapped_q[idx];
        mapped_q.delete(idx);
        return v;
    endfunction

    // Drive one cycle of inputs and advance the model across the coming clock edge.
    task automatic apply_stimulus(input logic [1:0] deq, input logic [1:0] enq,
                                  input int v0, input int v1,
                                  input logic fl, input logic rs);
        status_t s;
        int      vals [2];
        int      n_enq;
        int      v;
        @(posedge clk);
        #1;
        dequeue_en     = deq;
        enqueue_en     = enq;
        enqueue_phy[0] = v0[PRF_IDX-1:0];
        enqueue_phy[1] = v1[PRF_IDX-1:0];
        flush          = fl;
        rst            = rs;
        s.cnt = free_q.size();
        s.rdy = (free_q.size() >= 2) ? 1 : 0;
        s.emp = (free_q.size() == 0) ? 1 : 0;
        stat_q.push_back(s);
        if (!rs) begin
            model_reset();
            return;
        end
        if (s.rdy == 1 && !fl) begin
            for (int k = 0; k < 2; k++) begin
                if (deq[k]) begin
                    v = free_q.pop_front();
                    exp_q.push_back(v);
                    spec_q.push_back(v);
                end
            end
        end
        vals[0] = v0;
        vals[1] = v1;
        n_enq   = 0;
        for (int j = 0; j < 2; j++) begin
            if (enq[j]) begin
                free_q.push_back(vals[j]);
                drop_mapped(vals[j]);
                n_enq++;
            end
        end
        repeat (n_enq) mapped_q.push_back(spec_q.pop_front());
        if (fl) begin
            free_q = {spec_q, free_q};
            spec_q.delete();
        end
    endtask

    // Monitor: compares status every cycle and pops one expectation per granted lane.
    initial begin
        status_t s;
        forever begin
            @(negedge clk);
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                check_output("count", 32'(count), s.cnt);
                check_output("dequeue_ready", 32'(dequeue_ready), s.rdy);
                check_output("empty", 32'(empty), s.emp);
                if (rst && !flush && dequeue_ready) begin
                    for (int k = 0; k < 2; k++) begin
                        if (dequeue_en[k]) begin
                            if (exp_q.size() == 0) begin
                                n_vec++;
                                n_miss++;
                                $display("[TB] FAIL unexpected_grant lane%0d: got %0d expected no grant", k, dequeue_phy[k]);
                            end else begin
                                check_output($sformatf("dequeue_phy[%0d]", k), 32'(dequeue_phy[k]), exp_q.pop_front());
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [1:0] d;
        logic [1:0] e;
        int         a;
        int         b;
        logic       f;
        logic       r;

        rst         = 1'b0;
        dequeue_en  = '0;
        enqueue_en  = '0;
        enqueue_phy = '0;
        flush       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        // Two-lane allocation straight out of reset.
        apply_stimulus(2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
        apply_stimulus(2'b11, 2'b00, 0, 0, 1'b0, 1'b1);
        apply_stimulus(2'b11, 2'b00, 0, 0, 1'b0, 1'b1);
        apply_stimulus(2'b00, 2'b00, 0, 0, 1'b0, 1'b1);

        // Lane compaction when only the upper lane requests.
        apply_stimulus(2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
        apply_stimulus(2'b10, 2'b00, 0, 0, 1'b0, 1'b1);
        apply_stimulus(2'b11, 2'b00, 0, 0, 1'b0, 1'b1);

        // Drain to one entry, stall, then refill through commit.
        apply_stimulus(2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
        repeat (15) apply_stimulus(2'b11, 2'b00, 0, 0, 1'b0, 1'b1);
        apply_stimulus(2'b01, 2'b00, 0, 0, 1'b0, 1'b1);
        repeat (3) apply_stimulus(2'b11, 2'b00, 0, 0, 1'b0, 1'b1);
        apply_stimulus(2'b11, 2'b01, 5, 0, 1'b0, 1'b1);
        apply_stimulus(2'b11, 2'b00, 0, 0, 1'b0, 1'b1);
        apply_stimulus(2'b00, 2'b00, 0, 0, 1'b0, 1'b1);

        // Allocate six, commit two, flush back to the retired head.
        apply_stimulus(2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
        repeat (3) apply_stimulus(2'b11, 2'b00, 0, 0, 1'b0, 1'b1);
        apply_stimulus(2'b00, 2'b11, 7, 9, 1'b0, 1'b1);
        apply_stimulus(2'b00, 2'b00, 0, 0, 1'b1, 1'b1);
        apply_stimulus(2'b01, 2'b00, 0, 0, 1'b0, 1'b1);
        apply_stimulus(2'b11, 2'b00, 0, 0, 1'b0, 1'b1);

        // Flush coinciding with a two-lane commit and an ignored dequeue.
        apply_stimulus(2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
        repeat (2) apply_stimulus(2'b11, 2'b00, 0, 0, 1'b0, 1'b1);
        apply_stimulus(2'b11, 2'b11, 10, 11, 1'b1, 1'b1);
        apply_stimulus(2'b11, 2'b00, 0, 0, 1'b0, 1'b1);
        apply_stimulus(2'b11, 2'b00, 0, 0, 1'b0, 1'b1);

        // Random traffic with occasional flushes and a reset in the middle.
        apply_stimulus(2'b00, 2'b00, 0, 0, 1'b0, 1'b0);
        for (int c = 0; c < 400; c++) begin
            d = 2'($urandom);
            e = 2'($urandom);
            if (spec_q.size() == 0) e = 2'b00;
            else if (spec_q.size() == 1 && e == 2'b11) e = 2'b01;
            a = e[0] ? pick_mapped() : 0;
            b = e[1] ? pick_mapped() : 0;
            f = ($urandom_range(0, 15) == 0);
            r = !(c == 200 || c == 201);
            apply_stimulus(d, e, a, b, f, r);
        end

        apply_stimulus(2'b00, 2'b00, 0, 0, 1'b0, 1'b1);
        apply_stimulus(2'b00, 2'b00, 0, 0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check_output("pending_grants", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
